// File: rtl/led_flasher.sv
// led_flasher: flashes an LED a requested number of times per trigger.
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   trig  in   single-cycle request pulse (debounced/synchronized upstream)
//   count in   [3:0] flashes requested, sampled with trig (0 treated as 1)
//   led   out  registered LED drive
//   busy  out  registered, high while a sequence runs or one is queued
//   done  out  registered single-cycle completion pulse
module led_flasher #(
  parameter int unsigned DIV       = 500000,
  parameter int unsigned ON_TICKS  = 20,
  parameter int unsigned OFF_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [3:0] count,
  output logic       led,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned T_MAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TICK_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [DIV_W-1:0]    r_div, w_div_nx;
  logic [TICK_W-1:0]   r_tick, w_tick_nx;
  logic [3:0]          r_rem, w_rem_nx;
  logic                r_pend, w_pend_nx;
  logic [3:0]          r_pend_cnt, w_pend_cnt_nx;
  logic                w_led_nx, w_busy_nx, w_done_nx;
  logic                w_tick;

  assign w_tick = (r_div == DIV_W'(DIV - 1));

  // A queued request is launched from IDLE in the cycle after completion;
  // busy is held high through that cycle so the gap is invisible upstream.
  always_comb begin
    w_state_nx    = r_state;
    w_div_nx      = r_div;
    w_tick_nx     = r_tick;
    w_rem_nx      = r_rem;
    w_pend_nx     = r_pend;
    w_pend_cnt_nx = r_pend_cnt;
    w_led_nx      = 1'b0;
    w_busy_nx     = busy;
    w_done_nx     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_div_nx  = '0;
        w_tick_nx = '0;
        if (r_pend) begin
          w_state_nx = S_ON;
          w_rem_nx   = (r_pend_cnt == 4'd0) ? 4'd1 : r_pend_cnt;
          w_pend_nx  = 1'b0;
          w_led_nx   = 1'b1;
          w_busy_nx  = 1'b1;
        end else if (trig) begin
          w_state_nx = S_ON;
          w_rem_nx   = (count == 4'd0) ? 4'd1 : count;
          w_led_nx   = 1'b1;
          w_busy_nx  = 1'b1;
        end else begin
          w_busy_nx  = 1'b0;
        end
      end

      S_ON: begin
        w_led_nx  = 1'b1;
        w_busy_nx = 1'b1;
        if (w_tick) begin
          w_div_nx = '0;
          if (r_tick == TICK_W'(ON_TICKS - 1)) begin
            w_tick_nx = '0;
            w_led_nx  = 1'b0;
            if (r_rem > 4'd1) begin
              w_rem_nx   = r_rem - 4'd1;
              w_state_nx = S_OFF;
            end else begin
              w_state_nx = S_IDLE;
              w_done_nx  = 1'b1;
              // stays busy if a request is queued, including one arriving now
              w_busy_nx  = r_pend | trig;
            end
          end else begin
            w_tick_nx = r_tick + TICK_W'(1);
          end
        end else begin
          w_div_nx = r_div + DIV_W'(1);
        end
      end

      S_OFF: begin
        w_busy_nx = 1'b1;
        if (w_tick) begin
          w_div_nx = '0;
          if (r_tick == TICK_W'(OFF_TICKS - 1)) begin
            w_tick_nx  = '0;
            w_state_nx = S_ON;
            w_led_nx   = 1'b1;
          end else begin
            w_tick_nx = r_tick + TICK_W'(1);
          end
        end else begin
          w_div_nx = r_div + DIV_W'(1);
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_div_nx   = '0;
        w_tick_nx  = '0;
        w_busy_nx  = 1'b0;
      end
    endcase

    // newest request wins the single pending slot
    if (trig && busy) begin
      w_pend_nx     = 1'b1;
      w_pend_cnt_nx = count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_tick     <= '0;
      r_rem      <= '0;
      r_pend     <= 1'b0;
      r_pend_cnt <= '0;
      led        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_div      <= w_div_nx;
      r_tick     <= w_tick_nx;
      r_rem      <= w_rem_nx;
      r_pend     <= w_pend_nx;
      r_pend_cnt <= w_pend_cnt_nx;
      led        <= w_led_nx;
      busy       <= w_busy_nx;
      done       <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_led_flasher.sv
// Directed bench for led_flasher with DIV=4, ON_TICKS=2, OFF_TICKS=3.
module tb_led_flasher;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [3:0] count;
  logic       led;
  logic       busy;
  logic       done;

  int unsigned n_cmp;
  int unsigned n_err;

  led_flasher #(
    .DIV       (4),
    .ON_TICKS  (2),
    .OFF_TICKS (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .trig  (trig),
    .count (count),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle c is the cycle whose closing edge samples the stimulus set for c;
  // outputs observed #1 after that edge belong to cycle c+1.
  task automatic run_scn(input string nm, input int ncyc,
                         input int t0, input logic [3:0] c0,
                         input int t1, input logic [3:0] c1,
                         input int t2, input logic [3:0] c2,
                         input int rst_at,
                         input logic [63:0] e_led,
                         input logic [63:0] e_busy,
                         input logic [63:0] e_done);
    logic [63:0] el, eb, ed;
    el = e_led; eb = e_busy; ed = e_done;
    for (int c = 0; c <= ncyc; c++) begin
      check_eq($sformatf("%s led c%0d", nm, c),  {31'd0, led},  {31'd0, el[c]});
      check_eq($sformatf("%s busy c%0d", nm, c), {31'd0, busy}, {31'd0, eb[c]});
      check_eq($sformatf("%s done c%0d", nm, c), {31'd0, done}, {31'd0, ed[c]});
      trig  = 1'b0;
      count = '0;
      rst   = (c == rst_at);
      if (c == t0) begin trig = 1'b1; count = c0; end
      if (c == t1) begin trig = 1'b1; count = c1; end
      if (c == t2) begin trig = 1'b1; count = c2; end
      step();
    end
    trig  = 1'b0;
    count = '0;
    rst   = 1'b0;
    for (int k = 0; k < 4; k++) step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    trig  = 1'b0;
    count = '0;
    step();
    step();
    check_eq("reset led",  {31'd0, led},  32'd0);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    step();

    // single flash
    run_scn("cnt1", 12, 0, 4'd1, -1, 4'd0, -1, 4'd0, -1,
            rng(1, 8), rng(1, 8), rng(9, 9));
    // two flashes with one OFF gap
    run_scn("cnt2", 31, 0, 4'd2, -1, 4'd0, -1, 4'd0, -1,
            rng(1, 8) | rng(21, 28), rng(1, 28), rng(29, 29));
    // count of zero behaves as one
    run_scn("cnt0", 12, 0, 4'd0, -1, 4'd0, -1, 4'd0, -1,
            rng(1, 8), rng(1, 8), rng(9, 9));
    // queued request, newest count wins
    run_scn("pend", 21, 0, 4'd1, 4, 4'd3, 6, 4'd1, -1,
            rng(1, 8) | rng(10, 17), rng(1, 17), rng(9, 9) | rng(18, 18));
    // reset mid-sequence aborts without done, then restart
    run_scn("rstmid", 27, 0, 4'd2, 15, 4'd1, -1, 4'd0, 12,
            rng(1, 8) | rng(16, 23), rng(1, 12) | rng(16, 23), rng(24, 24));
    // trig coincident with reset is ignored
    run_scn("rsttrig", 6, 0, 4'd3, -1, 4'd0, -1, 4'd0, 0,
            64'd0, 64'd0, 64'd0);
    // trig on the last ON cycle is queued
    run_scn("lastOn", 21, 0, 4'd1, 8, 4'd1, -1, 4'd0, -1,
            rng(1, 8) | rng(10, 17), rng(1, 17), rng(9, 9) | rng(18, 18));
    // trig in the completion cycle with nothing queued starts from IDLE
    run_scn("compl", 21, 0, 4'd1, 9, 4'd1, -1, 4'd0, -1,
            rng(1, 8) | rng(10, 17), rng(1, 8) | rng(10, 17), rng(9, 9) | rng(18, 18));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
